// File: rtl/pwm_breathe_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_breathe_multi_if
// Purpose  : Configuration write port for pwm_breathe_multi. A write is
//            accepted on a rising clock edge where cfg_valid and cfg_ready
//            are both high.
// Signals  : cfg_valid  master->slave  write request
//            cfg_ready  slave->master  write can be accepted
//            cfg_ch     master->slave  target channel index
//            cfg_mode   master->slave  00 off, 01 static, 10 breathe, 11 on
//            cfg_duty   master->slave  static duty value
// Revision : 1.0  initial release
// ============================================================================
interface pwm_breathe_multi_if #(
  parameter int NUM_CH   = 3,
  parameter int PWM_BITS = 8
);
  localparam int c_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                cfg_valid;
  logic                cfg_ready;
  logic [c_CH_W-1:0]   cfg_ch;
  logic [1:0]          cfg_mode;
  logic [PWM_BITS-1:0] cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_mode,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_mode,
    input  cfg_duty,
    output cfg_ready
  );
endinterface
`default_nettype wire

// File: rtl/pwm_breathe_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_breathe_multi
// Purpose  : Multi-channel PWM LED driver. NUM_CH channels share one
//            free-running PWM counter; each channel is off, static duty,
//            triangle breathe or fully on. Settings written through the cfg
//            port are staged and only become active at a PWM period boundary
//            so the LED waveforms never glitch.
// Ports    : CLK          system clock
//            RST          asynchronous active-high reset
//            cfg          configuration write port (slave modport)
//            LED          registered LED drive pins, polarity per ACTIVE_LOW
//            period_tick  high on the last clock of every PWM period
// Revision : 1.0  initial release
// ============================================================================
module pwm_breathe_multi #(
  parameter int                 NUM_CH       = 3,
  parameter int                 PWM_BITS     = 8,
  parameter int                 STEP_PERIODS = 256,
  parameter int                 ACTIVE_LOW   = 1,
  parameter logic [1:0]         RESET_MODE   = 2'b10,
  parameter logic [NUM_CH-1:0]  INIT_DIR     = {NUM_CH{1'b1}}
) (
  input  wire logic               CLK,
  input  wire logic               RST,
  pwm_breathe_multi_if.slave      cfg,
  output logic [NUM_CH-1:0]       LED,
  output logic                    period_tick
);

  localparam int                  c_CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int                  c_STEP_W    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] c_MAX       = {PWM_BITS{1'b1}};
  localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_PERIODS - 1);
  localparam logic                c_UNLIT     = (ACTIVE_LOW != 0);

  localparam logic [1:0] c_MODE_OFF     = 2'b00;
  localparam logic [1:0] c_MODE_STATIC  = 2'b01;
  localparam logic [1:0] c_MODE_BREATHE = 2'b10;

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [c_STEP_W-1:0] r_step_cnt;
  logic                r_cfg_ready;
  logic [NUM_CH-1:0]   r_led;

  logic                w_boundary;
  logic                w_step;
  logic                w_wr_en;
  logic [NUM_CH-1:0]   w_lit;

  assign w_boundary    = (r_pwm_cnt == c_MAX);
  // Breathe levels advance only on the boundary that completes a step interval.
  assign w_step        = w_boundary && (r_step_cnt == c_STEP_LAST);
  assign w_wr_en       = cfg.cfg_valid && r_cfg_ready;

  assign period_tick   = w_boundary;
  assign cfg.cfg_ready = r_cfg_ready;
  assign LED           = r_led;

  // Shared PWM counter, breathe step counter and write-ready flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pwm_cnt   <= '0;
      r_step_cnt  <= '0;
      r_cfg_ready <= 1'b0;
    end else begin
      r_cfg_ready <= 1'b1;
      r_pwm_cnt   <= r_pwm_cnt + 1'b1;
      if (w_boundary) begin
        r_step_cnt <= w_step ? '0 : (r_step_cnt + 1'b1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [1:0]          r_pend_mode;
    logic [1:0]          r_act_mode;
    logic [PWM_BITS-1:0] r_pend_duty;
    logic [PWM_BITS-1:0] r_act_duty;
    logic [PWM_BITS-1:0] r_level;
    logic                r_dir;
    logic                w_sel;
    logic                w_enter;
    logic                w_lit_ch;

    // Out-of-range channel indices match no channel, so such writes vanish.
    assign w_sel   = w_wr_en && (cfg.cfg_ch == c_CH_W'(gi));
    assign w_enter = (r_pend_mode == c_MODE_BREATHE) && (r_act_mode != c_MODE_BREATHE);

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_pend_mode <= RESET_MODE;
        r_act_mode  <= RESET_MODE;
        r_pend_duty <= '0;
        r_act_duty  <= '0;
        r_dir       <= INIT_DIR[gi];
        r_level     <= INIT_DIR[gi] ? '0 : c_MAX;
      end else begin
        if (w_sel) begin
          r_pend_mode <= cfg.cfg_mode;
          r_pend_duty <= cfg.cfg_duty;
        end
        // The load samples the pending values from before this edge; a
        // write landing on the same edge waits for the next boundary.
        if (w_boundary) begin
          r_act_mode <= r_pend_mode;
          r_act_duty <= r_pend_duty;
          if (w_enter) begin
            r_level <= '0;
            r_dir   <= 1'b1;
          end else if (w_step && (r_act_mode == c_MODE_BREATHE)) begin
            // Triangle with no dwell: the end value is shown once, then the
            // direction flips and the neighbour value follows immediately.
            if (r_dir) begin
              if (r_level == c_MAX) begin
                r_dir   <= 1'b0;
                r_level <= c_MAX - 1'b1;
              end else begin
                r_level <= r_level + 1'b1;
              end
            end else begin
              if (r_level == '0) begin
                r_dir   <= 1'b1;
                r_level <= PWM_BITS'(1);
              end else begin
                r_level <= r_level - 1'b1;
              end
            end
          end
        end
      end
    end

    // Full-on mode bypasses the compare so the MAX count is lit as well.
    always_comb begin
      w_lit_ch = 1'b0;
      case (r_act_mode)
        c_MODE_OFF:     w_lit_ch = 1'b0;
        c_MODE_STATIC:  w_lit_ch = (r_pwm_cnt < r_act_duty);
        c_MODE_BREATHE: w_lit_ch = (r_pwm_cnt < r_level);
        default:        w_lit_ch = 1'b1;
      endcase
    end

    assign w_lit[gi] = w_lit_ch;
  end

  // Registered output: the lit window appears one clock after the compare.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_led <= {NUM_CH{c_UNLIT}};
    end else begin
      r_led <= w_lit ^ {NUM_CH{c_UNLIT}};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_breathe_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_breathe_multi
// Purpose  : Self-checking bench for pwm_breathe_multi (NUM_CH=3, PWM_BITS=4,
//            STEP_PERIODS=2, ACTIVE_LOW=1, RESET_MODE=00). Stimulus pushes
//            the expected lit count of each channel for chosen PWM periods
//            into a queue; a monitor captures each period's lit pattern and
//            compares it when the period closes.
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm_breathe_multi;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] LED;
  logic       period_tick;

  int checks   = 0;
  int failures = 0;
  int tb_cnt   = 0;   // bench copy of the PWM count
  int tb_per   = 0;   // index of the PWM period now running

  typedef struct {
    int win;
    int n0;
    int n1;
    int n2;
  } exp_t;
  exp_t exp_q[$];

  pwm_breathe_multi_if #(.NUM_CH(3), .PWM_BITS(4)) cfg_if ();

  pwm_breathe_multi #(
    .NUM_CH(3), .PWM_BITS(4), .STEP_PERIODS(2), .ACTIVE_LOW(1), .RESET_MODE(2'b00)
  ) dut (
    .CLK(CLK), .RST(RST), .cfg(cfg_if), .LED(LED), .period_tick(period_tick)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  // Lit pattern of a period with n lit compare cycles: first n samples lit.
  function automatic logic [15:0] pat_of(input int n);
    logic [15:0] one;
    one = 16'd1;
    if (n >= 16) return 16'hFFFF;
    return (one << n) - 16'd1;
  endfunction

  task automatic push(input int win, input int n0, input int n1, input int n2);
    exp_t e;
    e.win = win; e.n0 = n0; e.n1 = n1; e.n2 = n2;
    exp_q.push_back(e);
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      tb_cnt <= 0;
      tb_per <= 0;
    end else begin
      if (tb_cnt == 15) tb_per <= tb_per + 1;
      tb_cnt <= (tb_cnt + 1) % 16;
    end
  end

  always @(negedge CLK) begin
    if (!RST) check("period_tick", int'(period_tick), (tb_cnt == 15) ? 1 : 0);
  end

  // Monitor: a window is the 16 LED samples for one period's compares,
  // closed on the sample right after period_tick.
  initial begin : monitor
    logic [15:0] pat [3];
    int  k;
    int  win;
    bit  prev_tick;
    k = 0; win = 0; prev_tick = 1'b0;
    for (int c = 0; c < 3; c++) pat[c] = '0;
    forever begin
      @(negedge CLK);
      if (RST || !cfg_if.cfg_ready) begin
        k = 0; win = 0; prev_tick = 1'b0;
        for (int c = 0; c < 3; c++) pat[c] = '0;
      end else begin
        for (int c = 0; c < 3; c++) if (k < 16) pat[c][k] = ~LED[c];
        k++;
        if (prev_tick) begin
          while (exp_q.size() > 0 && exp_q[0].win <= win) begin
            if (exp_q[0].win < win) begin
              check("scoreboard_missed_window", exp_q[0].win, win);
            end else begin
              check($sformatf("win%0d_led0", win), int'(pat[0]), int'(pat_of(exp_q[0].n0)));
              check($sformatf("win%0d_led1", win), int'(pat[1]), int'(pat_of(exp_q[0].n1)));
              check($sformatf("win%0d_led2", win), int'(pat[2]), int'(pat_of(exp_q[0].n2)));
            end
            void'(exp_q.pop_front());
          end
          k = 0;
          win++;
          for (int c = 0; c < 3; c++) pat[c] = '0;
        end
        prev_tick = period_tick;
      end
    end
  end

  task automatic goto(input int c);
    do begin
      @(posedge CLK);
      #2;
    end while (tb_cnt != c);
  endtask

  // Issued just after an edge; accepted on the next edge. eff is the first
  // period that runs with the new setting.
  task automatic cfg_write(input int ch, input int mode, input int duty, output int eff);
    eff = (tb_cnt == 15) ? tb_per + 2 : tb_per + 1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_mode  = 2'(mode);
    cfg_if.cfg_duty  = 4'(duty);
    @(posedge CLK);
    #2;
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge CLK);
      n++;
    end
    #2;
    check("scoreboard_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin : stim
    int e;
    int p;
    int lvl;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_mode  = '0;
    cfg_if.cfg_duty  = '0;
    RST = 1'b1;

    // Reset state and release
    repeat (3) begin
      @(negedge CLK);
      check("rst_led", int'(LED), 3'b111);
      check("rst_ready", int'(cfg_if.cfg_ready), 0);
      check("rst_tick", int'(period_tick), 0);
    end
    @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("ready_before_edge", int'(cfg_if.cfg_ready), 0);
    @(posedge CLK);
    #1;
    check("ready_after_edge", int'(cfg_if.cfg_ready), 1);
    push(0, 0, 0, 0);

    // ch1 static duty 5, written mid-period
    goto(6);
    p = tb_per;
    cfg_write(1, 1, 5, e);
    push(p, 0, 0, 0);
    push(e, 0, 5, 0);
    push(e + 1, 0, 5, 0);

    // ch0 duty boundaries: 0, 15, then full on
    goto(3); cfg_write(0, 1, 0, e);  push(e, 0, 5, 0);
    goto(3); cfg_write(0, 1, 15, e); push(e, 15, 5, 0);
    goto(3); cfg_write(0, 3, 0, e);  push(e, 16, 5, 0); push(e + 1, 16, 5, 0);

    // ch2 breathe, entered on a step boundary so each level spans two periods
    do goto(3); while (tb_per % 2 == 0);
    cfg_write(2, 2, 0, e);
    for (int j = 0; j < 32; j++) begin
      lvl = ((j % 30) <= 15) ? (j % 30) : (30 - (j % 30));
      push(e + 2 * j, 16, 5, lvl);
      push(e + 2 * j + 1, 16, 5, lvl);
    end
    drain(64 * 16 + 200);

    // Write timing at the boundary and out-of-range channel
    goto(3);  cfg_write(2, 0, 0, e);
    goto(14); cfg_write(1, 1, 9, e); push(e, 16, 9, 0);
    goto(15); cfg_write(1, 1, 3, e); push(e - 1, 16, 9, 0); push(e, 16, 3, 0);
    goto(3);  cfg_write(3, 1, 12, e); push(e, 16, 3, 0); push(e + 1, 16, 3, 0);
    check("ready_after_ignored_write", int'(cfg_if.cfg_ready), 1);
    drain(200);

    // Async reset mid-period with channels lit
    goto(3);
    cfg_write(1, 1, 12, e);
    do goto(7); while (tb_per < e);
    check("led_before_rst", int'(LED), 3'b100);
    RST = 1'b1;
    #1;
    check("led_async_rst", int'(LED), 3'b111);
    check("tick_async_rst", int'(period_tick), 0);
    check("ready_async_rst", int'(cfg_if.cfg_ready), 0);
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    push(0, 0, 0, 0);
    push(1, 0, 0, 0);
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    failures++;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
